// File: rtl/fft_band_pkg.sv
// Shared types for the FFT octave-band level stage.
// Band count, band index, level type and the FSM state encoding.
package fft_band_pkg;

   localparam int NUM_BANDS = 9;

   typedef logic [3:0] band_t;
   typedef logic [7:0] level_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      SCALE,
      PUBLISH
   } state_t;

endpackage

// File: rtl/fft_band_log2_enc.sv
// Priority encoder: bin index -> octave band (floor(log2(idx))).
// Flags bin 0 (DC), which belongs to no band.
module fft_band_log2_enc
   import fft_band_pkg::*;
#(
   parameter int IDX_W = 9
) (
   input  logic [IDX_W-1:0] idx,
   output band_t            band,
   output logic             dc
);

   always_comb begin
      band = '0;
      for (int i = 0; i < IDX_W; i++) begin
         if (idx[i]) band = band_t'(i);
      end
      dc = (idx == '0);
   end

endmodule

// File: rtl/fft_band_levels.sv
// Folds an FFT magnitude frame into 9 octave band levels for the VGA bars.
// Peak-hold/decay of levels is enabled by defining FFT_BAND_PEAK_HOLD_EN.
module fft_band_levels
   import fft_band_pkg::*;
#(
   parameter int MAG_W       = 16,
   parameter int NUM_BINS    = 512,
   parameter int LEVEL_W     = 8,
   parameter int LEVEL_SHIFT = 6,
   parameter int DECAY       = 4,
   parameter int THRESH      = 64
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   input  logic               bin_valid,
   output logic               bin_ready,
   input  logic               bin_sop,
   input  logic               bin_eop,
   input  logic [MAG_W-1:0]   bin_mag,
   input  logic [3:0]         rd_band,
   output logic [LEVEL_W-1:0] rd_level,
   output logic [8:0]         lights,
   output logic               frame_done
);

   localparam int IDX_W = $clog2(NUM_BINS);
   localparam int SUM_W = MAG_W + 8;

   if ((NUM_BINS & (NUM_BINS - 1)) != 0 || IDX_W != NUM_BANDS
       || DECAY < 0) begin : g_bad_cfg
      $error("fft_band_levels: unsupported NUM_BINS or DECAY");
   end

   state_t             state, state_nx;
   logic [IDX_W:0]     idx;
   band_t              scan;
   logic [SUM_W-1:0]   sums   [NUM_BANDS];
   logic [LEVEL_W-1:0] shadow [NUM_BANDS];
   logic [LEVEL_W-1:0] held   [NUM_BANDS];

   logic               accept;
   logic [IDX_W-1:0]   eff_idx;
   logic               in_range;
   band_t              band;
   logic               dc;
   logic [SUM_W:0]     sum_add;
   logic [SUM_W-1:0]   sum_sat;
   logic [SUM_W-1:0]   avg;
   logic [SUM_W-1:0]   pre;
   logic [LEVEL_W-1:0] lvl;
   logic [LEVEL_W-1:0] lvl_nx;

   assign accept   = bin_valid && bin_ready;
   assign eff_idx  = bin_sop ? '0 : idx[IDX_W-1:0];
   // idx reaching NUM_BINS sets the top bit: further beats are dropped
   assign in_range = bin_sop || !idx[IDX_W];

   fft_band_log2_enc #(.IDX_W(IDX_W)) u_enc (
      .idx  (eff_idx),
      .band (band),
      .dc   (dc)
   );

   assign sum_add = {1'b0, sums[band]}
                  + {{(SUM_W + 1 - MAG_W){1'b0}}, bin_mag};
   assign sum_sat = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];

   always_comb begin
      avg    = sums[scan] >> scan;
      pre    = avg >> LEVEL_SHIFT;
      lvl    = (|pre[SUM_W-1:LEVEL_W]) ? '1 : pre[LEVEL_W-1:0];
      lvl_nx = lvl;
`ifdef FFT_BAND_PEAK_HOLD_EN
      if (lvl < held[scan]) begin
         if (held[scan] > LEVEL_W'(DECAY))
            lvl_nx = held[scan] - LEVEL_W'(DECAY);
         else
            lvl_nx = '0;
      end
`endif
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) state <= IDLE;
      else             state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      bin_ready = 1'b1;
      case (state)
         IDLE: begin
            if (bin_valid && bin_sop)
               state_nx = bin_eop ? SCALE : ACCUM;
         end
         ACCUM: begin
            if (bin_valid && bin_eop) state_nx = SCALE;
         end
         SCALE: begin
            bin_ready = 1'b0;
            if (scan == band_t'(NUM_BANDS - 1)) state_nx = PUBLISH;
         end
         PUBLISH: begin
            bin_ready = 1'b0;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         idx        <= '0;
         scan       <= '0;
         lights     <= '0;
         frame_done <= 1'b0;
         rd_level   <= '0;
         for (int b = 0; b < NUM_BANDS; b++) begin
            sums[b]   <= '0;
            shadow[b] <= '0;
            held[b]   <= '0;
         end
      end else begin
         frame_done <= (state == PUBLISH);
         // during PUBLISH read the incoming bank so readback flips with lights
         if (rd_band < band_t'(NUM_BANDS))
            rd_level <= (state == PUBLISH) ? shadow[rd_band] : held[rd_band];
         else
            rd_level <= '0;
         case (state)
            IDLE, ACCUM: begin
               if (accept && bin_sop) begin
                  idx <= {{IDX_W{1'b0}}, 1'b1};
                  for (int b = 0; b < NUM_BANDS; b++) sums[b] <= '0;
               end else if (accept && state == ACCUM) begin
                  if (in_range && !dc) sums[band] <= sum_sat;
                  if (!idx[IDX_W]) idx <= idx + 1'b1;
               end
            end
            SCALE: begin
               shadow[scan] <= lvl_nx;
               scan <= (scan == band_t'(NUM_BANDS - 1)) ? '0 : scan + 1'b1;
            end
            PUBLISH: begin
               for (int b = 0; b < NUM_BANDS; b++) begin
                  held[b]   <= shadow[b];
                  lights[b] <= (shadow[b] >= LEVEL_W'(THRESH));
                  sums[b]   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_band_levels.sv
// Directed self-checking bench for fft_band_levels.
// Expectations follow FFT_BAND_PEAK_HOLD_EN when it is defined.
module tb_fft_band_levels;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic        bin_valid;
   logic        bin_ready;
   logic        bin_sop;
   logic        bin_eop;
   logic [15:0] bin_mag;
   logic [3:0]  rd_band;
   logic [7:0]  rd_level;
   logic [8:0]  lights;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   always #5 clk_clk = ~clk_clk;

   fft_band_levels dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .bin_valid   (bin_valid),
      .bin_ready   (bin_ready),
      .bin_sop     (bin_sop),
      .bin_eop     (bin_eop),
      .bin_mag     (bin_mag),
      .rd_band     (rd_band),
      .rd_level    (rd_level),
      .lights      (lights),
      .frame_done  (frame_done)
   );

   // 0 silent, 1 tone at bin 40, 2 full scale, 3 band3 = 100, 4 band2 = 128
   function automatic logic [15:0] bin_val(input int mode, input int i);
      case (mode)
         1:       return (i == 40) ? 16'h4000 : 16'h0000;
         2:       return 16'hFFFF;
         3:       return (i >= 8 && i < 16) ? 16'd6400 : 16'd0;
         4:       return (i >= 4 && i < 8) ? 16'h2000 : 16'h0000;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic do_reset();
      reset_reset = 1'b1;
      bin_valid   = 1'b0;
      bin_sop     = 1'b0;
      bin_eop     = 1'b0;
      bin_mag     = '0;
      repeat (2) @(posedge clk_clk);
      #1 reset_reset = 1'b0;
   endtask

   task automatic beat(input logic sop, input logic eop,
                       input logic [15:0] mag);
      bin_valid = 1'b1;
      bin_sop   = sop;
      bin_eop   = eop;
      bin_mag   = mag;
      @(posedge clk_clk);
      #1;
      bin_valid = 1'b0;
      bin_sop   = 1'b0;
      bin_eop   = 1'b0;
   endtask

   task automatic send_frame(input int mode);
      for (int i = 0; i < 512; i++)
         beat(i == 0, i == 511, bin_val(mode, i));
   endtask

   // lat counts the eop edge as 1; gives up after 40
   task automatic wait_done(output int lat);
      lat = 1;
      while (!frame_done && lat < 40) begin
         @(posedge clk_clk);
         #1;
         lat++;
      end
   endtask

   task automatic read_level(input int b, output logic [7:0] v);
      rd_band = 4'(b);
      @(posedge clk_clk);
      #1;
      v = rd_level;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      do_reset();
      checks++;
      if (bin_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b exp 1", bin_ready);
      end
      checks++;
      if (lights !== 9'h000) begin
         errors++;
         $display("FAIL reset_lights got %h exp 000", lights);
      end
      checks++;
      if (frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done got %b exp 0", frame_done);
      end
      for (int b = 0; b < 9; b += 4) begin
         read_level(b, v);
         checks++;
         if (v !== 8'd0) begin
            errors++;
            $display("FAIL reset_level%0d got %0d exp 0", b, v);
         end
      end
   endtask

   task automatic test_single_tone();
      logic [7:0] v;
      int lat;
      do_reset();
      send_frame(1);
      wait_done(lat);
      checks++;
      if (lat !== 11) begin
         errors++;
         $display("FAIL tone_latency got %0d exp 11", lat);
      end
      checks++;
      if (lights !== 9'h000) begin
         errors++;
         $display("FAIL tone_lights got %h exp 000", lights);
      end
      for (int b = 0; b < 9; b++) begin
         read_level(b, v);
         checks++;
         if (v !== ((b == 5) ? 8'd8 : 8'd0)) begin
            errors++;
            $display("FAIL tone_level%0d got %0d exp %0d",
                     b, v, (b == 5) ? 8 : 0);
         end
      end
   endtask

   task automatic test_saturation();
      logic [7:0] v;
      int lat;
      do_reset();
      send_frame(2);
      wait_done(lat);
      checks++;
      if (lights !== 9'h1FF) begin
         errors++;
         $display("FAIL sat_lights got %h exp 1ff", lights);
      end
      for (int b = 0; b < 9; b++) begin
         read_level(b, v);
         checks++;
         if (v !== 8'd255) begin
            errors++;
            $display("FAIL sat_level%0d got %0d exp 255", b, v);
         end
      end
      for (int b = 9; b < 16; b += 6) begin
         read_level(b, v);
         checks++;
         if (v !== 8'd0) begin
            errors++;
            $display("FAIL sat_oob%0d got %0d exp 0", b, v);
         end
      end
   endtask

   task automatic test_peak_decay();
      logic [7:0] v;
      int lat;
`ifdef FFT_BAND_PEAK_HOLD_EN
      int exp_lvl [4] = '{100, 96, 92, 88};
      logic exp_bit [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
      int exp_lvl [4] = '{100, 0, 0, 0};
      logic exp_bit [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif
      do_reset();
      for (int f = 0; f < 4; f++) begin
         send_frame((f == 0) ? 3 : 0);
         wait_done(lat);
         checks++;
         if (lights[3] !== exp_bit[f]) begin
            errors++;
            $display("FAIL decay_light%0d got %b exp %b",
                     f, lights[3], exp_bit[f]);
         end
         read_level(3, v);
         checks++;
         if (v !== 8'(exp_lvl[f])) begin
            errors++;
            $display("FAIL decay_level%0d got %0d exp %0d",
                     f, v, exp_lvl[f]);
         end
      end
   endtask

   task automatic test_restart();
      logic [7:0] v;
      int lat;
      int seen;
      do_reset();
      for (int i = 0; i < 5; i++) beat(1'b0, i == 4, 16'hFFFF);
      seen = 0;
      repeat (14) begin
         @(posedge clk_clk);
         #1;
         if (frame_done) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL stray_done got %0d pulses exp 0", seen);
      end
      for (int i = 0; i < 200; i++) beat(i == 0, 1'b0, 16'hFFFF);
      for (int i = 0; i < 512; i++) beat(i == 0, i == 511, bin_val(1, i));
      wait_done(lat);
      checks++;
      if (lat !== 11) begin
         errors++;
         $display("FAIL restart_latency got %0d exp 11", lat);
      end
      checks++;
      if (lights !== 9'h000) begin
         errors++;
         $display("FAIL restart_lights got %h exp 000", lights);
      end
      for (int b = 0; b < 9; b++) begin
         read_level(b, v);
         checks++;
         if (v !== ((b == 5) ? 8'd8 : 8'd0)) begin
            errors++;
            $display("FAIL restart_level%0d got %0d exp %0d",
                     b, v, (b == 5) ? 8 : 0);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      logic [7:0] exp;
      int lat;
      int low;
      do_reset();
      send_frame(1);
      bin_valid = 1'b1;
      bin_sop   = 1'b1;
      bin_eop   = 1'b0;
      bin_mag   = 16'hFFFF;
      low = 0;
      while (!bin_ready && low < 30) begin
         @(posedge clk_clk);
         #1;
         low++;
      end
      checks++;
      if (low !== 10) begin
         errors++;
         $display("FAIL b2b_ready_low got %0d cycles exp 10", low);
      end
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done1 got %b exp 1", frame_done);
      end
      @(posedge clk_clk);
      #1;
      for (int i = 1; i < 512; i++) beat(1'b0, i == 511, bin_val(4, i));
      wait_done(lat);
      checks++;
      if (lat !== 11) begin
         errors++;
         $display("FAIL b2b_latency got %0d exp 11", lat);
      end
      checks++;
      if (lights !== 9'h004) begin
         errors++;
         $display("FAIL b2b_lights got %h exp 004", lights);
      end
      for (int b = 0; b < 9; b++) begin
`ifdef FFT_BAND_PEAK_HOLD_EN
         exp = (b == 2) ? 8'd128 : (b == 5) ? 8'd4 : 8'd0;
`else
         exp = (b == 2) ? 8'd128 : 8'd0;
`endif
         read_level(b, v);
         checks++;
         if (v !== exp) begin
            errors++;
            $display("FAIL b2b_level%0d got %0d exp %0d", b, v, exp);
         end
      end
   endtask

   task automatic test_one_bin();
      logic [7:0] v;
      int lat;
      do_reset();
      beat(1'b1, 1'b1, 16'hFFFF);
      wait_done(lat);
      checks++;
      if (lat !== 11) begin
         errors++;
         $display("FAIL onebin_latency got %0d exp 11", lat);
      end
      checks++;
      if (lights !== 9'h000) begin
         errors++;
         $display("FAIL onebin_lights got %h exp 000", lights);
      end
      for (int b = 0; b < 9; b += 8) begin
         read_level(b, v);
         checks++;
         if (v !== 8'd0) begin
            errors++;
            $display("FAIL onebin_level%0d got %0d exp 0", b, v);
         end
      end
   endtask

   task automatic test_reset_mid_scale();
      logic [7:0] v;
      int lat;
      int seen;
      do_reset();
      send_frame(1);
      repeat (3) @(posedge clk_clk);
      #1 reset_reset = 1'b1;
      @(posedge clk_clk);
      #1 reset_reset = 1'b0;
      seen = 0;
      repeat (15) begin
         @(posedge clk_clk);
         #1;
         if (frame_done) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midrst_done got %0d pulses exp 0", seen);
      end
      checks++;
      if (lights !== 9'h000) begin
         errors++;
         $display("FAIL midrst_lights got %h exp 000", lights);
      end
      read_level(5, v);
      checks++;
      if (v !== 8'd0) begin
         errors++;
         $display("FAIL midrst_level5 got %0d exp 0", v);
      end
      send_frame(1);
      wait_done(lat);
      checks++;
      if (lat !== 11) begin
         errors++;
         $display("FAIL midrst_latency got %0d exp 11", lat);
      end
      read_level(5, v);
      checks++;
      if (v !== 8'd8) begin
         errors++;
         $display("FAIL midrst_level5_after got %0d exp 8", v);
      end
   endtask

   initial begin
      reset_reset = 1'b1;
      bin_valid   = 1'b0;
      bin_sop     = 1'b0;
      bin_eop     = 1'b0;
      bin_mag     = '0;
      rd_band     = '0;
      test_reset();
      test_single_tone();
      test_saturation();
      test_peak_decay();
      test_restart();
      test_back_to_back();
      test_one_bin();
      test_reset_mid_scale();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
